// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing one unified memory between the IF fetch port and the MM load/store port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise MM has fixed priority over IF.
module mem_arbiter #(
  parameter int width   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [width-1:0] if_addr,
  output logic             if_ack,
  output logic [width-1:0] if_rdata,
  input  logic             mm_req,
  input  logic             mm_we,
  input  logic [width-1:0] mm_addr,
  input  logic [width-1:0] mm_wdata,
  input  logic [3:0]       mm_be,
  output logic             mm_ack,
  output logic [width-1:0] mm_rdata,
  output logic             err,
  output logic             busy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [width-1:0] mem_addr,
  output logic [width-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_rvalid,
  input  logic [width-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q;
  logic             grant_mm_q;
  logic [CW-1:0]    cnt_q;
  logic             if_ack_q, mm_ack_q, err_q, busy_q;
  logic             mem_req_q, mem_we_q;
  logic [width-1:0] if_rdata_q, mm_rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]       mem_be_q;
  logic             grant_mm_d;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;  // 1 = MM won last

  always_comb begin
    grant_mm_d = mm_req;
    if (if_req && mm_req) grant_mm_d = !last_grant_q;
  end
`else
  assign grant_mm_d = mm_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_mm_q  <= 1'b0;
      cnt_q       <= '0;
      if_ack_q    <= 1'b0;
      mm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      mm_rdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      // NOTE: pulse outputs default low with non-blocking assignments so each state only raises what it owns.
      mem_req_q <= 1'b0;
      if_ack_q  <= 1'b0;
      mm_ack_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (if_req || mm_req) begin
            grant_mm_q  <= grant_mm_d;
            mem_we_q    <= grant_mm_d ? mm_we : 1'b0;
            mem_addr_q  <= grant_mm_d ? mm_addr : if_addr;
            mem_wdata_q <= grant_mm_d ? mm_wdata : '0;
            mem_be_q    <= grant_mm_d ? mm_be : 4'hF;
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= grant_mm_d;
`endif
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (grant_mm_q) mm_rdata_q <= mem_rdata;
            else            if_rdata_q <= mem_rdata;
            err_q    <= 1'b0;
            if_ack_q <= !grant_mm_q;
            mm_ack_q <= grant_mm_q;
            state_q  <= RESP;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            // The memory is assumed never to answer a command after it has timed out.
            if (grant_mm_q) mm_rdata_q <= '0;
            else            if_rdata_q <= '0;
            err_q    <= 1'b1;
            if_ack_q <= !grant_mm_q;
            mm_ack_q <= grant_mm_q;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign mm_ack    = mm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mm_rdata  = mm_rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a requester/memory model drives traffic, a monitor checks every ack.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         if_req, mm_req, mm_we, mem_rvalid;
  logic [W-1:0] if_addr, mm_addr, mm_wdata, mem_rdata;
  logic [3:0]   mm_be;
  logic         if_ack, mm_ack, err, busy, mem_req, mem_we;
  logic [W-1:0] if_rdata, mm_rdata, mem_addr, mem_wdata;
  logic [3:0]   mem_be;

  always #5 clk = ~clk;

  mem_arbiter #(.width(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_be(mm_be),
    .mm_ack(mm_ack), .mm_rdata(mm_rdata), .err(err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic         is_mm;
    logic [W-1:0] rdata;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Memory model and command log
  bit           mem_respond = 1'b1;
  int           mem_delay   = 1;
  bit           pend        = 1'b0;
  int           cd          = 0;
  logic [W-1:0] resp_data   = '0;
  int           mreq_cnt    = 0;
  int           cmd_cyc     = 0;
  logic         cmd_we;
  logic [W-1:0] cmd_addr, cmd_wdata;
  logic [3:0]   cmd_be;

  function automatic logic [W-1:0] data_for(input logic [W-1:0] a);
    if (a == 32'h40) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic exp_t mk(input logic is_mm, input logic [W-1:0] rd, input logic e);
    exp_t x;
    x.is_mm = is_mm;
    x.rdata = rd;
    x.err   = e;
    return x;
  endfunction

  // One cycle: memory responds per its delay, requesters drop req on the cycle they see ack.
  task automatic step();
    @(negedge clk);
    cyc++;
    mem_rvalid = 1'b0;
    if (pend) begin
      cd--;
      if (cd == 0) begin
        pend       = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = resp_data;
      end
    end
    if (mem_req) begin
      mreq_cnt++;
      cmd_cyc   = cyc;
      cmd_we    = mem_we;
      cmd_addr  = mem_addr;
      cmd_wdata = mem_wdata;
      cmd_be    = mem_be;
      if (mem_respond) begin
        pend      = 1'b1;
        cd        = mem_delay;
        resp_data = data_for(mem_addr);
      end
    end
    if (if_ack) if_req = 1'b0;
    if (mm_ack) mm_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (if_ack || mm_ack) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_ack: if_ack=%b mm_ack=%b at cycle %0d, none expected", if_ack, mm_ack, cyc);
        end else begin
          exp_t e;
          logic [W-1:0] got;
          e   = sb.pop_front();
          got = mm_ack ? mm_rdata : if_rdata;
          if ((if_ack && mm_ack) || mm_ack !== e.is_mm || got !== e.rdata || err !== e.err) begin
            n_err++;
            $display("FAIL ack_check: got if_ack=%b mm_ack=%b rdata=%h err=%b, want mm=%b rdata=%h err=%b",
                     if_ack, mm_ack, got, err, e.is_mm, e.rdata, e.err);
          end
        end
      end else if (err !== 1'b0) begin
        n_cmp++;
        n_err++;
        $display("FAIL err_without_ack: err=%b, want 0 at cycle %0d", err, cyc);
      end
    end
  end

  function automatic logic [4*W+13:0] all_outs();
    return {if_ack, mm_ack, err, busy, mem_req, mem_we, if_rdata, mm_rdata, mem_addr, mem_wdata, mem_be};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, want 0", all_outs());
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_reset: busy=%b mem_req=%b, want 0/0", busy, mem_req);
      end
    end
  endtask

  task automatic test_if_fetch();
    int n0, t0, ack_cyc;
    ack_cyc   = -1;
    mem_delay = 2;
    n0        = mreq_cnt;
    step();
    t0      = cyc;
    if_addr = 32'h40;
    if_req  = 1'b1;
    sb.push_back(mk(1'b0, 32'h0050_0093, 1'b0));
    for (int i = 0; i < 20 && ack_cyc < 0; i++) begin
      step();
      if (cyc == t0 + 1) begin
        n_cmp++;
        if (busy !== 1'b1 || mem_req !== 1'b1) begin
          n_err++;
          $display("FAIL fetch_issue: busy=%b mem_req=%b, want 1/1", busy, mem_req);
        end
      end
      if (if_ack) ack_cyc = cyc;
    end
    n_cmp++;
    if (ack_cyc - t0 != 4) begin
      n_err++;
      $display("FAIL fetch_latency: got %0d cycles, want 4", ack_cyc - t0);
    end
    n_cmp++;
    if (mreq_cnt - n0 != 1 || cmd_addr !== 32'h40 || cmd_we !== 1'b0 || cmd_be !== 4'hF) begin
      n_err++;
      $display("FAIL fetch_cmd: count=%0d addr=%h we=%b be=%h, want 1/00000040/0/f", mreq_cnt - n0, cmd_addr, cmd_we, cmd_be);
    end
    step();
    n_cmp++;
    if (if_ack !== 1'b0 || if_rdata !== 32'h0050_0093) begin
      n_err++;
      $display("FAIL fetch_hold: if_ack=%b if_rdata=%h, want 0/00500093", if_ack, if_rdata);
    end
  endtask

  task automatic test_mm_store();
    int t0, ack_cyc;
    bit saw_if_ack;
    ack_cyc    = -1;
    saw_if_ack = 1'b0;
    mem_delay  = 1;
    step();
    t0       = cyc;
    mm_addr  = 32'h100;
    mm_wdata = 32'hDEAD_BEEF;
    mm_be    = 4'b0011;
    mm_we    = 1'b1;
    mm_req   = 1'b1;
    sb.push_back(mk(1'b1, data_for(32'h100), 1'b0));
    for (int i = 0; i < 20 && ack_cyc < 0; i++) begin
      step();
      if (if_ack) saw_if_ack = 1'b1;
      if (mm_ack) ack_cyc = cyc;
    end
    n_cmp++;
    if (cmd_we !== 1'b1 || cmd_addr !== 32'h100 || cmd_wdata !== 32'hDEAD_BEEF || cmd_be !== 4'b0011) begin
      n_err++;
      $display("FAIL store_cmd: we=%b addr=%h wdata=%h be=%b, want 1/00000100/deadbeef/0011", cmd_we, cmd_addr, cmd_wdata, cmd_be);
    end
    n_cmp++;
    if (ack_cyc - t0 != 3 || saw_if_ack) begin
      n_err++;
      $display("FAIL store_ack: latency=%0d if_ack_seen=%b, want 3/0", ack_cyc - t0, saw_if_ack);
    end
    mm_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n0, acks, first_cyc;
    logic [W-1:0] first_addr, want_first;
    acks      = 0;
    first_cyc = -1;
    mem_delay = 1;
    n0        = mreq_cnt;
    step();
    if_addr = 32'h80;
    mm_addr = 32'h200;
    mm_we   = 1'b0;
    mm_be   = 4'hF;
    if_req  = 1'b1;
    mm_req  = 1'b1;
`ifdef MEM_ARB_RR_EN
    want_first = 32'h80;
    sb.push_back(mk(1'b0, data_for(32'h80), 1'b0));
    sb.push_back(mk(1'b1, data_for(32'h200), 1'b0));
`else
    want_first = 32'h200;
    sb.push_back(mk(1'b1, data_for(32'h200), 1'b0));
    sb.push_back(mk(1'b0, data_for(32'h80), 1'b0));
`endif
    for (int i = 0; i < 30 && acks < 2; i++) begin
      step();
      if (mreq_cnt == n0 + 1 && first_cyc < 0) begin
        first_cyc  = cmd_cyc;
        first_addr = cmd_addr;
      end
      if (if_ack || mm_ack) acks++;
    end
    n_cmp++;
    if (acks != 2) begin
      n_err++;
      $display("FAIL b2b_acks: got %0d, want 2", acks);
    end
    n_cmp++;
    if (first_addr !== want_first) begin
      n_err++;
      $display("FAIL b2b_order: first addr %h, want %h", first_addr, want_first);
    end
    n_cmp++;
    if (cmd_cyc - first_cyc != 4) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d cycles, want 4", cmd_cyc - first_cyc);
    end
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (mreq_cnt - n0 != 2) begin
      n_err++;
      $display("FAIL b2b_cmd_count: got %0d, want 2", mreq_cnt - n0);
    end
  endtask

  task automatic test_timeout();
    int t0, ack_cyc;
    ack_cyc     = -1;
    mem_respond = 1'b0;
    step();
    t0      = cyc;
    if_addr = 32'h300;
    if_req  = 1'b1;
    sb.push_back(mk(1'b0, 32'h0, 1'b1));
    for (int i = 0; i < 40 && ack_cyc < 0; i++) begin
      step();
      if (if_ack) ack_cyc = cyc;
    end
    n_cmp++;
    if (ack_cyc - t0 != TO + 3) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d cycles, want %0d", ack_cyc - t0, TO + 3);
    end
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL late_rvalid: busy=%b mem_req=%b if_rdata=%h, want 0/0/00000000", busy, mem_req, if_rdata);
      end
    end
    mem_respond = 1'b1;
  endtask

  task automatic test_reset_in_wait();
    int t0, ack_cyc;
    ack_cyc     = -1;
    mem_respond = 1'b0;
    step();
    if_addr = 32'h44;
    if_req  = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL reset_in_wait: outputs %h, want 0", all_outs());
    end
    if_req = 1'b0;
    pend   = 1'b0;
    step();
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0 || if_ack !== 1'b0 || if_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL post_reset_idle: busy=%b if_ack=%b if_rdata=%h, want 0/0/00000000", busy, if_ack, if_rdata);
      end
    end
    mem_respond = 1'b1;
    mem_delay   = 1;
    step();
    t0     = cyc;
    if_req = 1'b1;
    sb.push_back(mk(1'b0, data_for(32'h44), 1'b0));
    for (int i = 0; i < 20 && ack_cyc < 0; i++) begin
      step();
      if (if_ack) ack_cyc = cyc;
    end
    n_cmp++;
    if (ack_cyc - t0 != 3) begin
      n_err++;
      $display("FAIL rerequest_latency: got %0d cycles, want 3", ack_cyc - t0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    if_req     = 1'b0;
    mm_req     = 1'b0;
    mm_we      = 1'b0;
    mem_rvalid = 1'b0;
    if_addr    = '0;
    mm_addr    = '0;
    mm_wdata   = '0;
    mm_be      = '0;
    mem_rdata  = '0;
    test_reset();
    test_if_fetch();
    test_mm_store();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected acks never seen, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
